preadder8: RTL and testbench
============================

PREADDER8 -- requirements
Module: preadder8

Interface
REQ-001 The module SHALL have exactly one parameter: WIDTH, default 8, the operand and sum width in bits; only 8 is required to be supported.
REQ-002 The port `clk` SHALL be an input, 1 bit wide, and serve as the single clock; all state updates occur on its rising edge.
REQ-003 The port `rst_n` SHALL be an input, 1 bit wide, and act as the reset; reset is synchronous and active-low.
REQ-004 The port `in_valid` SHALL be an input, 1 bit wide, and qualify `a`, `b` and `cin` in the current cycle.
REQ-005 The port `a` SHALL be an input, WIDTH bits wide, carrying operand A (unsigned or two's complement).
REQ-006 The port `b` SHALL be an input, WIDTH bits wide, carrying operand B.
REQ-007 The port `cin` SHALL be an input, 1 bit wide, carrying the carry-in.
REQ-008 The port `sum` SHALL be an output, WIDTH bits wide, carrying (a + b + cin) mod 2^WIDTH, registered.
REQ-009 The port `cout` SHALL be an output, 1 bit wide, carrying the carry-out of bit WIDTH-1, registered.
REQ-010 The port `overflow` SHALL be an output, 1 bit wide, indicating signed two's-complement overflow, registered.
REQ-011 The port `zero` SHALL be an output, 1 bit wide, set to 1 when `sum` is all zeros, registered.
REQ-012 The port `out_valid` SHALL be an output, 1 bit wide, marking the cycle in which `sum`, `cout`, `overflow` and `zero` are valid.

Function
REQ-013 Sum and carry SHALL be computed combinationally by a parallel-prefix (Kogge-Stone) network: per-bit generate g=a&b and propagate p=a^b, then log2(WIDTH)=3 prefix levels with spans 1, 2 and 4, then sum[i]=p[i]^c[i] with c[0]=cin.
REQ-014 `cin` SHALL be folded in as the generate signal of a virtual bit -1, so it reaches every bit within the same 3 levels.
REQ-015 Latency SHALL be exactly 1 cycle: inputs sampled at edge N with in_valid=1 SHALL appear on the outputs after edge N, with out_valid=1.
REQ-016 If in_valid=0 at a rising edge, out_valid SHALL go to 0 at that edge, and sum/cout/overflow/zero SHALL hold their previous values.
REQ-017 There SHALL be no backpressure: a new operand set SHALL be accepted every cycle, for a throughput of 1 per clock.
REQ-018 overflow SHALL equal c[WIDTH-1] XOR cout, which is equivalent to a[7]==b[7] && sum[7]!=a[7].
REQ-019 zero SHALL be computed from the same-cycle sum (a NOR-reduce of sum) and registered alongside it, with no extra latency.
REQ-020 All flags SHALL be produced on every valid cycle regardless of signed or unsigned interpretation; the consumer selects cout (unsigned) or overflow (signed).
REQ-021 The combinational paths in and out SHALL contain no latches.

Reset
REQ-022 When rst_n=0 at a rising edge, sum, cout, overflow, zero and out_valid SHALL all be 0 after that edge.
REQ-023 zero=0 under reset is intentional, since flags are meaningful only while out_valid=1.
REQ-024 Reset asserted in the same cycle as in_valid=1 SHALL win: the operand set is discarded and out_valid=0.
REQ-025 In the first edge after rst_n returns to 1, the block SHALL accept inputs normally.

Structure
REQ-026 The constant LEVELS=3 (log2 of WIDTH) SHALL live in the shared package preadder8_pkg; no typedefs are required.
REQ-027 A single sub-module preadder8_pg_cell SHALL implement the prefix operator: (G,P) = (Gh | Ph&Gl, Ph&Pl).
REQ-028 preadder8_pg_cell SHALL be instantiated via generate loops, and gray cells SHALL be permitted where P is unused.
REQ-029 The output register stage SHALL be the only sequential logic in the block.

Verification
REQ-030 a=0x7F, b=0x01, cin=0, in_valid=1 -> next cycle: sum=0x80, cout=0, overflow=1, zero=0, out_valid=1.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0, zero=1.
REQ-032 a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, overflow=1, zero=1; then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, overflow=0, zero=1.
REQ-033 Back-to-back stream 0x12+0x34 (cin=0), then 0x0F+0xF0 (cin=1), then in_valid=0 -> consecutive outputs 0x46 then 0x00 with cout=1, then out_valid=0 with values held.
REQ-034 rst_n=0 with in_valid=1 and a=0x55, b=0x55 -> all outputs 0 and out_valid=0; after release, 0x55+0x55 -> sum=0xAA, overflow=1, cout=0.
REQ-035 Random test: 10,000 random a/b/cin vectors SHALL be compared one cycle later against a behavioural a+b+cin model, covering all four outputs.

Source files
------------

// File: rtl/preadder8_pkg.sv
// Shared constants for the preadder8 Kogge-Stone adder.
package preadder8_pkg;
  localparam int LEVELS = 3;
endpackage

// File: rtl/preadder8_pg_cell.sv
// Kogge-Stone prefix operator: (G,P) = (Gh | Ph&Gl, Ph&Pl).
module preadder8_pg_cell (
  input  logic i_gh,
  input  logic i_ph,
  input  logic i_gl,
  input  logic i_pl,
  output logic o_g,
  output logic o_p
);
  assign o_g = i_gh | (i_ph & i_gl);
  assign o_p = i_ph & i_pl;
endmodule

// File: rtl/preadder8.sv
// Registered 8-bit Kogge-Stone adder with carry, signed overflow and zero flags.
module preadder8
  import preadder8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);
  logic [WIDTH-1:0]             w_bg, w_bp, w_c, w_sum;
  logic [LEVELS:0][WIDTH-1:0]   w_g, w_p;
  logic                         w_cout, w_ovf, w_unused_p;

  assign w_bg = a & b;
  assign w_bp = a ^ b;

  // Node 0 is the virtual bit -1 carrying cin; node j holds bit j-1.
  assign w_g[0] = {w_bg[WIDTH-2:0], cin};
  assign w_p[0] = {w_bp[WIDTH-2:0], 1'b0};

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int SPAN = 1 << l;
    for (genvar j = 0; j < WIDTH; j++) begin : g_node
      if (j >= SPAN) begin : g_cell
        preadder8_pg_cell u_pg (
          .i_gh (w_g[l][j]),
          .i_ph (w_p[l][j]),
          .i_gl (w_g[l][j-SPAN]),
          .i_pl (w_p[l][j-SPAN]),
          .o_g  (w_g[l+1][j]),
          .o_p  (w_p[l+1][j])
        );
      end else begin : g_pass
        assign w_g[l+1][j] = w_g[l][j];
        assign w_p[l+1][j] = w_p[l][j];
      end
    end
  end

  // Final-level group propagates are not needed; only carries leave the tree.
  assign w_unused_p = ^w_p[LEVELS];

  assign w_c    = w_g[LEVELS];
  assign w_sum  = w_bp ^ w_c;
  assign w_cout = w_bg[WIDTH-1] | (w_bp[WIDTH-1] & w_c[WIDTH-1]);
  assign w_ovf  = w_c[WIDTH-1] ^ w_cout;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf, r_zero, r_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
        r_zero <= ~|w_sum;
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign out_valid = r_vld;
endmodule

// File: tb/tb_preadder8.sv
// Directed and random checks of preadder8 against hand-computed and a+b+cin results.
module tb_preadder8;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, cin;
  logic [7:0] a, b;
  logic [7:0] sum;
  logic       cout, overflow, zero, out_valid;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  preadder8 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero), .out_valid(out_valid)
  );

  task automatic drive(input logic v, input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
    @(negedge clk);
    in_valid = v; a = ta; b = tb_; cin = tc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    checks++;
    if ({out_valid, sum, cout, overflow, zero} !== 12'h000) begin
      failures++;
      $display("FAIL reset: got vld=%b sum=%h c=%b ov=%b z=%b expected all 0",
               out_valid, sum, cout, overflow, zero);
    end
    rst_n = 1'b1;
  endtask

  // expected packed as {vld, sum, cout, ovf, zero}
  task automatic test_vec(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tc, input logic [11:0] exp);
    drive(1'b1, ta, tb_, tc);
    checks++;
    if ({out_valid, sum, cout, overflow, zero} !== exp) begin
      failures++;
      $display("FAIL %s: got vld=%b sum=%h c=%b ov=%b z=%b expected %h",
               nm, out_valid, sum, cout, overflow, zero, exp);
    end
  endtask

  task automatic test_flags();
    test_vec("ovf_7f_01",  8'h7F, 8'h01, 1'b0, {1'b1, 8'h80, 1'b0, 1'b1, 1'b0});
    test_vec("carry_ff_01", 8'hFF, 8'h01, 1'b0, {1'b1, 8'h00, 1'b1, 1'b0, 1'b1});
    test_vec("ovf_80_80",  8'h80, 8'h80, 1'b0, {1'b1, 8'h00, 1'b1, 1'b1, 1'b1});
    test_vec("cin_ff_00",  8'hFF, 8'h00, 1'b1, {1'b1, 8'h00, 1'b1, 1'b0, 1'b1});
    test_vec("cin_only",   8'h00, 8'h00, 1'b1, {1'b1, 8'h01, 1'b0, 1'b0, 1'b0});
    test_vec("neg_ovf",    8'hC0, 8'hB0, 1'b1, {1'b1, 8'h71, 1'b1, 1'b1, 1'b0});
  endtask

  task automatic test_back_to_back();
    test_vec("b2b_first",  8'h12, 8'h34, 1'b0, {1'b1, 8'h46, 1'b0, 1'b0, 1'b0});
    test_vec("b2b_second", 8'h0F, 8'hF0, 1'b1, {1'b1, 8'h00, 1'b1, 1'b0, 1'b1});
    drive(1'b0, 8'hAA, 8'h11, 1'b1);
    checks++;
    if ({out_valid, sum, cout, overflow, zero} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL b2b_hold: got vld=%b sum=%h c=%b ov=%b z=%b expected vld=0 sum=00 c=1 ov=0 z=1",
               out_valid, sum, cout, overflow, zero);
    end
  endtask

  task automatic test_reset_wins();
    test_vec("pre_rst", 8'h01, 8'h02, 1'b0, {1'b1, 8'h03, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b0;
    drive(1'b1, 8'h55, 8'h55, 1'b0);
    checks++;
    if ({out_valid, sum, cout, overflow, zero} !== 12'h000) begin
      failures++;
      $display("FAIL rst_wins: got vld=%b sum=%h c=%b ov=%b z=%b expected all 0",
               out_valid, sum, cout, overflow, zero);
    end
    rst_n = 1'b1;
    test_vec("post_rst", 8'h55, 8'h55, 1'b0, {1'b1, 8'hAA, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic test_random();
    logic [7:0]  ra, rb;
    logic        rc;
    logic [8:0]  full;
    logic [11:0] exp;
    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      exp = {1'b1, full[7:0], full[8],
             (ra[7] == rb[7]) && (full[7] != ra[7]), full[7:0] == 8'h00};
      drive(1'b1, ra, rb, rc);
      checks++;
      if ({out_valid, sum, cout, overflow, zero} !== exp) begin
        failures++;
        $display("FAIL random a=%h b=%h cin=%b: got vld=%b sum=%h c=%b ov=%b z=%b expected %h",
                 ra, rb, rc, out_valid, sum, cout, overflow, zero, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_flags();
    test_back_to_back();
    test_reset_wins();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
